// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode encoding and widths for the execute-stage ALU.
// Contents: alu_op_e (4-bit opcode enum), DATA_W, CTR_W.
// Optional feature macro used by the ALU: ALU_SHIFT_EN (compiles in the shifter).
package alu_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CTR_W  = 12;

    // Opcodes 1100-1111 are pass-through and are handled as the case default.
    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_XOR  = 4'b0001,
        OP_OR   = 4'b0010,
        OP_NOT  = 4'b0011,
        OP_LSL  = 4'b0100,
        OP_ADD  = 4'b0101,
        OP_SUB  = 4'b0110,
        OP_LSR  = 4'b0111,
        OP_LT   = 4'b1000,
        OP_EQ   = 4'b1001,
        OP_SUBC = 4'b1010,
        OP_NE   = 4'b1011
    } alu_op_e;

endpackage : alu_pkg

// File: rtl/alu_shifter.sv
// alu_shifter: combinational barrel shifter for LSL/LSR.
// Only instantiated when ALU_SHIFT_EN is defined.
// Ports:
//   data_in  [DATA_W-1:0] value to shift
//   amount   [2:0]        shift distance (0..7)
//   fill     1            bit shifted into vacated positions
//   dir_right 1           0 = shift left, 1 = shift right
//   result   [DATA_W-1:0] shifted value
//   carry    1            last bit shifted out (0 when amount is 0)
module alu_shifter
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] data_in,
    input  logic [2:0]        amount,
    input  logic              fill,
    input  logic              dir_right,
    output logic [DATA_W-1:0] result,
    output logic              carry
);

    localparam int unsigned EXT_W = 2 * DATA_W + 1;

    logic [EXT_W-1:0] ext_l;
    logic [EXT_W-1:0] ext_r;

    // Data sits between a guard bit (catches the carry) and a field of fill
    // bits, so a single shift produces the result, fill and carry together.
    // The guard bit is 0 before shifting, so a zero-length shift yields carry 0.
    always_comb begin
        ext_l  = {1'b0, data_in, {DATA_W{fill}}} << amount;
        ext_r  = {{DATA_W{fill}}, data_in, 1'b0} >> amount;
        result = '0;
        carry  = 1'b0;
        if (dir_right) begin
            result = ext_r[DATA_W:1];
            carry  = ext_r[0];
        end else begin
            result = ext_l[2*DATA_W-1:DATA_W];
            carry  = ext_l[EXT_W-1];
        end
    end

endmodule : alu_shifter

// File: rtl/alu.sv
// alu: combinational 8-bit execute-stage ALU plus a one-cycle registered
// copy of the instruction counter.
// Config macro: ALU_SHIFT_EN -- when defined, LSL/LSR use alu_shifter;
// otherwise those opcodes pass operand A through.
// Ports:
//   clk, reset         clock, synchronous active-high reset (alu_ctr only)
//   ALUOp [3:0]        operation select
//   inA, inB [7:0]     operands (inB[2:0] is the shift amount)
//   shiftcarry_in      carry-in for SUBC, fill bit for shifts
//   reg_file_ctr [11:0] counter issued with the instruction
//   rslt [7:0]         result (combinational)
//   shiftcarry_out     carry / no-borrow / shifted-out bit (combinational)
//   branchFlag         compare result (combinational)
//   alu_ctr [11:0]     reg_file_ctr delayed by one clock
module alu
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        ALUOp,
    input  logic [DATA_W-1:0] inA,
    input  logic [DATA_W-1:0] inB,
    input  logic              shiftcarry_in,
    input  logic [CTR_W-1:0]  reg_file_ctr,
    output logic [DATA_W-1:0] rslt,
    output logic              shiftcarry_out,
    output logic              branchFlag,
    output logic [CTR_W-1:0]  alu_ctr
);

    localparam int unsigned SUM_W  = DATA_W + 1;
    localparam int unsigned SUBC_W = DATA_W + 2;

    logic [SUM_W-1:0]  add_sum;
    logic [SUBC_W-1:0] subc_sum;
    logic [CTR_W-1:0]  alu_ctr_d;
    logic [CTR_W-1:0]  alu_ctr_q;

`ifdef ALU_SHIFT_EN
    logic [DATA_W-1:0] shift_rslt;
    logic              shift_carry;

    alu_shifter u_shifter (
        .data_in  (inA),
        .amount   (inB[2:0]),
        .fill     (shiftcarry_in),
        .dir_right(ALUOp == OP_LSR),
        .result   (shift_rslt),
        .carry    (shift_carry)
    );
`endif

    // 9-bit add; SUBC uses 10 bits so A + cin - B (range -255..256) keeps a
    // valid sign bit, whose inverse is the "A + cin >= B" carry.
    always_comb begin
        add_sum  = SUM_W'(inA) + SUM_W'(inB);
        subc_sum = SUBC_W'(inA) + SUBC_W'(shiftcarry_in) - SUBC_W'(inB);
    end

    // Opcode decode: defaults first, then per-opcode overrides.
    always_comb begin
        rslt           = inA;
        shiftcarry_out = 1'b0;
        branchFlag     = 1'b0;
        case (alu_op_e'(ALUOp))
            OP_AND: rslt = inA & inB;
            OP_XOR: rslt = inA ^ inB;
            OP_OR:  rslt = inA | inB;
            OP_NOT: rslt = ~inA;
`ifdef ALU_SHIFT_EN
            OP_LSL, OP_LSR: begin
                rslt           = shift_rslt;
                shiftcarry_out = shift_carry;
            end
`else
            OP_LSL, OP_LSR: rslt = inA;
`endif
            OP_ADD: begin
                rslt           = add_sum[DATA_W-1:0];
                shiftcarry_out = add_sum[DATA_W];
            end
            OP_SUB: begin
                rslt           = inA - inB;
                shiftcarry_out = (inA >= inB);
            end
            OP_LT: begin
                rslt       = '0;
                branchFlag = (inA < inB);
            end
            OP_EQ: begin
                rslt       = '0;
                branchFlag = (inA == inB);
            end
            OP_SUBC: begin
                rslt           = subc_sum[DATA_W-1:0];
                shiftcarry_out = ~subc_sum[SUBC_W-1];
            end
            OP_NE: begin
                rslt       = '0;
                branchFlag = (inA != inB);
            end
            default: rslt = inA;
        endcase
    end

    // Counter pipeline stage next value.
    always_comb begin
        alu_ctr_d = reg_file_ctr;
        if (reset) begin
            alu_ctr_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        alu_ctr_q <= alu_ctr_d;
    end

    assign alu_ctr = alu_ctr_q;

endmodule : alu

// File: tb/tb_alu.sv
// tb_alu: directed self-checking bench for alu.
// Expected shift results depend on ALU_SHIFT_EN being defined for the build.
module tb_alu;

    logic        clk;
    logic        reset;
    logic [3:0]  ALUOp;
    logic [7:0]  inA;
    logic [7:0]  inB;
    logic        shiftcarry_in;
    logic [11:0] reg_file_ctr;
    logic [7:0]  rslt;
    logic        shiftcarry_out;
    logic        branchFlag;
    logic [11:0] alu_ctr;

    int n_cmp;
    int n_err;

    alu dut (
        .clk           (clk),
        .reset         (reset),
        .ALUOp         (ALUOp),
        .inA           (inA),
        .inB           (inB),
        .shiftcarry_in (shiftcarry_in),
        .reg_file_ctr  (reg_file_ctr),
        .rslt          (rslt),
        .shiftcarry_out(shiftcarry_out),
        .branchFlag    (branchFlag),
        .alu_ctr       (alu_ctr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Apply one operation and check all three combinational outputs.
    task automatic run_vec(input string tag, input logic [3:0] op, input logic [7:0] a,
                           input logic [7:0] b, input logic cin, input logic [7:0] e_rslt,
                           input logic e_co, input logic e_bf);
        ALUOp         = op;
        inA           = a;
        inB           = b;
        shiftcarry_in = cin;
        #1;
        check_eq({tag, ".rslt"}, 16'(rslt), 16'(e_rslt));
        check_eq({tag, ".co"},   16'(shiftcarry_out), 16'(e_co));
        check_eq({tag, ".bf"},   16'(branchFlag), 16'(e_bf));
    endtask

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        reset         = 1'b1;
        ALUOp         = 4'b0000;
        inA           = 8'h00;
        inB           = 8'h00;
        shiftcarry_in = 1'b0;
        reg_file_ctr  = 12'h0AA;

        // Reset held for two edges; combinational path must still work.
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_eq("ctr_reset", 16'(alu_ctr), 16'h000);
        run_vec("and_in_reset", 4'b0000, 8'hAA, 8'hCC, 1'b0, 8'h88, 1'b0, 1'b0);

        // Logic
        run_vec("xor",  4'b0001, 8'hAA, 8'hCC, 1'b0, 8'h66, 1'b0, 1'b0);
        run_vec("or",   4'b0010, 8'hAA, 8'hCC, 1'b0, 8'hEE, 1'b0, 1'b0);
        run_vec("not",  4'b0011, 8'h3C, 8'hFF, 1'b1, 8'hC3, 1'b0, 1'b0);
        // Arithmetic
        run_vec("add1",  4'b0101, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);
        run_vec("addff", 4'b0101, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run_vec("sub21", 4'b0110, 8'h02, 8'h01, 1'b0, 8'h01, 1'b1, 1'b0);
        run_vec("sub12", 4'b0110, 8'h01, 8'h02, 1'b0, 8'hFF, 1'b0, 1'b0);
        run_vec("subeq", 4'b0110, 8'h07, 8'h07, 1'b1, 8'h00, 1'b1, 1'b0);
        // Compare
        run_vec("eq22", 4'b1001, 8'h02, 8'h02, 1'b0, 8'h00, 1'b0, 1'b1);
        run_vec("eq23", 4'b1001, 8'h02, 8'h03, 1'b0, 8'h00, 1'b0, 1'b0);
        run_vec("lt12", 4'b1000, 8'h01, 8'h02, 1'b0, 8'h00, 1'b0, 1'b1);
        run_vec("lt21", 4'b1000, 8'h02, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0);
        run_vec("ltff", 4'b1000, 8'h7F, 8'h80, 1'b0, 8'h00, 1'b0, 1'b1);
        run_vec("ne55", 4'b1011, 8'h05, 8'h05, 1'b0, 8'h00, 1'b0, 1'b0);
        run_vec("ne56", 4'b1011, 8'h05, 8'h06, 1'b0, 8'h00, 1'b0, 1'b1);
        // Subtract with carry
        run_vec("subc211", 4'b1010, 8'h02, 8'h01, 1'b1, 8'h02, 1'b1, 1'b0);
        run_vec("subc010", 4'b1010, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b0, 1'b0);
        run_vec("subc011", 4'b1010, 8'h00, 8'h01, 1'b1, 8'h00, 1'b1, 1'b0);
        run_vec("subcff",  4'b1010, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
        // Pass-through range
        run_vec("pass_c", 4'b1100, 8'h5A, 8'h11, 1'b1, 8'h5A, 1'b0, 1'b0);
        run_vec("pass_f", 4'b1111, 8'hA5, 8'h22, 1'b0, 8'hA5, 1'b0, 1'b0);
        // Shifts
`ifdef ALU_SHIFT_EN
        run_vec("lsl1",  4'b0100, 8'h81, 8'h01, 1'b0, 8'h02, 1'b1, 1'b0);
        run_vec("lsr1",  4'b0111, 8'h81, 8'h01, 1'b1, 8'hC0, 1'b1, 1'b0);
        run_vec("lsl0",  4'b0100, 8'h81, 8'h08, 1'b1, 8'h81, 1'b0, 1'b0);
        run_vec("lsr3",  4'b0111, 8'hF0, 8'h03, 1'b1, 8'hFE, 1'b0, 1'b0);
        run_vec("lsl7",  4'b0100, 8'h02, 8'h07, 1'b1, 8'h7F, 1'b1, 1'b0);
`else
        run_vec("lsl1",  4'b0100, 8'h81, 8'h01, 1'b0, 8'h81, 1'b0, 1'b0);
        run_vec("lsr1",  4'b0111, 8'h81, 8'h01, 1'b1, 8'h81, 1'b0, 1'b0);
`endif

        // Counter pipeline: drive away from the rising edge, check after it.
        @(negedge clk);
        reset = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            reg_file_ctr = 12'(i);
            @(posedge clk); #1;
            check_eq($sformatf("ctr_follow%0d", i), 16'(alu_ctr), 16'(i));
            @(negedge clk);
        end
        // Value held until the next edge.
        reg_file_ctr = 12'h7E5;
        #1;
        check_eq("ctr_hold", 16'(alu_ctr), 16'h005);

        // Mid-stream reset
        reset = 1'b1;
        @(posedge clk); #1;
        check_eq("ctr_rst_mid", 16'(alu_ctr), 16'h000);
        @(negedge clk);
        reg_file_ctr = 12'h123;
        @(posedge clk); #1;
        check_eq("ctr_rst_hold", 16'(alu_ctr), 16'h000);
        @(negedge clk);
        reset        = 1'b0;
        reg_file_ctr = 12'h456;
        @(posedge clk); #1;
        check_eq("ctr_after_rst", 16'(alu_ctr), 16'h456);
        @(negedge clk);
        reg_file_ctr = 12'hFFF;
        @(posedge clk); #1;
        check_eq("ctr_max", 16'(alu_ctr), 16'hFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_alu

// File: doc/alu.md
# alu

Combinational 8-bit ALU for the execute stage of the single-issue core. It performs logic, add/subtract, shift and compare operations on two register operands, selected by a 4-bit opcode from the decoder. Compare results feed the branch unit through `branchFlag`. A one-cycle registered copy of the program counter value, `alu_ctr`, travels alongside the result for the writeback and branch stages.

## Interface
Parameters: none; the widths are fixed.

- `clk` input 1: system clock. One clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `ALUOp` input 4: operation select.
- `inA` input 8: operand A.
- `inB` input 8: operand B; also the shift amount for shifts.
- `shiftcarry_in` input 1: carry-in for `SUBC` and bit shifted in for `LSL`/`LSR`.
- `reg_file_ctr` input 12: counter value issued with the current instruction.
- `rslt` output 8: operation result.
- `shiftcarry_out` output 1: carry, borrow or shifted-out bit.
- `branchFlag` output 1: compare result.
- `alu_ctr` output 12: registered `reg_file_ctr`.

## Operation
Opcodes (`ALUOp`) and behaviour. For every row, `branchFlag` = 0 and `shiftcarry_out` = 0 unless the row states otherwise.
- 0000 `AND`: `rslt` = A & B.
- 0001 `XOR`: `rslt` = A ^ B.
- 0010 `OR`: `rslt` = A | B.
- 0011 `NOT`: `rslt` = ~A.
- 0100 `LSL`: A shifted left by B[2:0]. Vacated bits are filled with `shiftcarry_in`. `shiftcarry_out` = last bit shifted out. A shift of 0 gives `rslt` = A and `shiftcarry_out` = 0.
- 0101 `ADD`: `rslt` = (A + B)[7:0]; `shiftcarry_out` = bit 8 of the 9-bit sum.
- 0110 `SUB`: `rslt` = (A − B)[7:0]; `shiftcarry_out` = 1 when A ≥ B unsigned (no borrow).
- 0111 `LSR`: logical right shift by B[2:0], mirror of `LSL`. Vacated MSBs are filled with `shiftcarry_in`.
- 1000 `LT`: `branchFlag` = (A < B) unsigned; `rslt` = 0.
- 1001 `EQ`: `branchFlag` = (A == B); `rslt` = 0.
- 1010 `SUBC`: `rslt` = (A − B + `shiftcarry_in`)[7:0]; `shiftcarry_out` = 1 when A + `shiftcarry_in` ≥ B.
- 1011 `NE`: `branchFlag` = (A != B); `rslt` = 0.
- 1100–1111: `rslt` = A (pass-through).
- All arithmetic is 9-bit unsigned internally and wraps modulo 256 on `rslt`. No signed overflow flag.

## Timing
- `rslt`, `shiftcarry_out` and `branchFlag` are purely combinational from `ALUOp`, `inA`, `inB` and `shiftcarry_in`. Latency is 0 cycles, and they are valid within the same cycle without any clock edge.
- `reset` does not affect the combinational outputs. They track their inputs even while `reset` is high.
- `alu_ctr`:
  - Registered with 1-cycle latency: `alu_ctr` = value of `reg_file_ctr` sampled at the previous rising edge of `clk`.
  - Reset value is 12'h000. It is cleared on the first rising edge with `reset` = 1 and held at 0 while `reset` stays high.
  - `reset` deasserted mid-stream: the first edge with `reset` = 0 captures `reg_file_ctr`.
- No handshake and no stall; a new operation may be applied every cycle.

## Configuration
- Macro `ALU_SHIFT_EN`.
- With the macro defined, opcodes 0100 (`LSL`) and 0111 (`LSR`) behave as specified above.
- Without the macro:
  - The shifter is not compiled in.
  - Opcodes 0100 and 0111 give `rslt` = A, `shiftcarry_out` = 0 and `branchFlag` = 0.
  - All other opcodes are unchanged.

## Structure
- Package `alu_pkg` contains:
  - `typedef enum logic [3:0] alu_op_e` with one entry per opcode listed under Operation;
  - `localparam DATA_W = 8`;
  - `localparam CTR_W = 12`.
- Sub-module `alu_shifter` is the natural split. It is combinational, instantiated only under `ALU_SHIFT_EN`, and has ports:
  - inputs: data, amount, fill bit, direction;
  - outputs: result, carry.
- The top level holds the opcode case statement and the `alu_ctr` register.

## Test plan
- Logic ops with A = 10101010, B = 11001100:
  - `AND` → 10001000;
  - `XOR` → 01100110;
  - `OR` → 11101110;
  - `branchFlag` = 0 for all three.
- Arithmetic:
  - `ADD` 1 + 1 → `rslt` = 00000010, carry 0;
  - `ADD` 0xFF + 0x01 → `rslt` = 0x00, `shiftcarry_out` = 1;
  - `SUB` 2 − 1 → 00000001, `shiftcarry_out` = 1;
  - `SUB` 1 − 2 → 0xFF, `shiftcarry_out` = 0.
- Compare:
  - `EQ` 2, 2 → `branchFlag` = 1;
  - `EQ` 2, 3 → 0;
  - `LT` 1, 2 → 1;
  - `NE` 5, 5 → 0.
- `SUBC` with A = 2, B = 1, `shiftcarry_in` = 1 → `rslt` = 00000010, `shiftcarry_out` = 1.
- Shift (with `ALU_SHIFT_EN`):
  - `LSL` A = 0x81, B = 1, cin = 0 → 0x02, `shiftcarry_out` = 1;
  - `LSR` A = 0x81, B = 1, cin = 1 → 0xC0, `shiftcarry_out` = 1.
  - Without the macro, the same stimuli → `rslt` = 0x81, `shiftcarry_out` = 0.
- `alu_ctr`:
  - With `reset` high for 2 cycles → `alu_ctr` = 0.
  - Then drive `reg_file_ctr` = 0x001, 0x002, … → `alu_ctr` follows one cycle later.
  - Reasserting `reset` mid-sequence → `alu_ctr` = 0 after the next edge.
